// File: rtl/ascii_conv_pkg.sv
// Shared definitions for the binary <-> ASCII decimal converters.
//   state_t    : controller states used by the converter FSMs
//   ASCII_ZERO : code of the character '0'; a decimal digit d maps to ASCII_ZERO + d
package ascii_conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary to packed-BCD converter, one bit per clock.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load bin_in, clear the BCD accumulator, arm BIN_WIDTH steps
//   bin_in     : unsigned binary value, sampled when start is high
//   done       : high during the cycle the final step is applied; bcd_out is
//                complete from the following cycle and held until the next start
//   bcd_out    : DIGITS_LENGTH packed BCD nibbles, least significant digit in [3:0]
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH     = 32,
  parameter int DIGITS_LENGTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BIN_WIDTH-1:0]       bin_in,
  output logic                       done,
  output logic [4*DIGITS_LENGTH-1:0] bcd_out
);

  localparam int BCD_W = 4 * DIGITS_LENGTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;

  // Pre-shift correction: any nibble >= 5 would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < DIGITS_LENGTH; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      bit_cnt   <= '0;
    end else if (start) begin
      shift_reg <= bin_in;
      bcd_reg   <= '0;
      bit_cnt   <= CNT_W'(BIN_WIDTH);
    end else if (bit_cnt != '0) begin
      bcd_reg   <= {bcd_adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
      shift_reg <= shift_reg << 1;
      bit_cnt   <= bit_cnt - CNT_W'(1);
    end
  end

  assign done    = (bit_cnt == CNT_W'(1));
  assign bcd_out = bcd_reg;

endmodule

// File: rtl/binary_to_ascii_converter.sv
// Converts an unsigned binary word into a fixed-length stream of decimal ASCII
// characters, most significant digit first, leading zeros included, over a
// valid/ready handshake.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   binary_data_in  : value to convert, captured when a start is accepted
//   start_in        : conversion request, accepted only while idle
//   busy_out        : high whenever a word is being converted or sent
//   ascii_char_out  : current character ('0'..'9'), 8'h00 when not valid
//   ascii_valid_out : character is valid
//   ascii_ready_in  : downstream takes the character this cycle
//   ascii_last_out  : current character is the last of the word
//
// state   | meaning
// IDLE    | waiting for start_in
// CONVERT | double-dabble running in bin_to_bcd_seq
// SEND    | presenting digit [digit_idx], counting down to digit 0
module binary_to_ascii_converter
  import ascii_conv_pkg::*;
#(
  parameter int BIN_WIDTH     = 32,
  parameter int DIGITS_LENGTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] binary_data_in,
  input  logic                 start_in,
  output logic                 busy_out,
  output logic [7:0]           ascii_char_out,
  output logic                 ascii_valid_out,
  input  logic                 ascii_ready_in,
  output logic                 ascii_last_out
);

  localparam int IDX_W = (DIGITS_LENGTH > 1) ? $clog2(DIGITS_LENGTH) : 1;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                digit_idx, digit_idx_nxt;
  logic                            conv_start;
  logic                            conv_done;
  logic [4*DIGITS_LENGTH-1:0]      bcd;
  logic [DIGITS_LENGTH-1:0][3:0]   digits;

  assign digits = bcd;

  bin_to_bcd_seq #(
    .BIN_WIDTH    (BIN_WIDTH),
    .DIGITS_LENGTH(DIGITS_LENGTH)
  ) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (conv_start),
    .bin_in (binary_data_in),
    .done   (conv_done),
    .bcd_out(bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      digit_idx <= '0;
    end else begin
      state     <= state_nxt;
      digit_idx <= digit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    digit_idx_nxt = digit_idx;
    conv_start    = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          conv_start = 1'b1;
          state_nxt  = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          state_nxt     = SEND;
          digit_idx_nxt = IDX_W'(DIGITS_LENGTH - 1);
        end
      end
      SEND: begin
        if (ascii_ready_in) begin
          if (digit_idx == '0) begin
            state_nxt = IDLE;
          end else begin
            digit_idx_nxt = digit_idx - IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Character and last flag depend only on registered state, so they cannot
  // change while a character is stalled by ascii_ready_in.
  assign busy_out        = (state != IDLE);
  assign ascii_valid_out = (state == SEND);
  assign ascii_last_out  = ascii_valid_out && (digit_idx == '0);
  assign ascii_char_out  = ascii_valid_out ? (ASCII_ZERO + {4'h0, digits[digit_idx]}) : 8'h00;

endmodule

// File: tb/tb_binary_to_ascii_converter.sv
module tb_binary_to_ascii_converter;

  localparam int BW = 32;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] binary_data_in;
  logic          start_in;
  logic          busy_out;
  logic [7:0]    ascii_char_out;
  logic          ascii_valid_out;
  logic          ascii_ready_in;
  logic          ascii_last_out;

  int total_checks  = 0;
  int passed_checks = 0;

  binary_to_ascii_converter #(.BIN_WIDTH(BW), .DIGITS_LENGTH(DL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .binary_data_in (binary_data_in),
    .start_in       (start_in),
    .busy_out       (busy_out),
    .ascii_char_out (ascii_char_out),
    .ascii_valid_out(ascii_valid_out),
    .ascii_ready_in (ascii_ready_in),
    .ascii_last_out (ascii_last_out)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] value;
    logic [79:0] text;
    int          mode;   // 0: ready high, 1: ready toggles, 2: random ready
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  // Reference: decimal digits by repeated division, least significant char in the low byte.
  function automatic logic [79:0] to_ascii(input logic [31:0] v);
    logic [79:0] r;
    longint      x;
    x = longint'(v);
    r = '0;
    for (int k = 0; k < DL; k++) begin
      r[8*k +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a clock edge with the DUT idle; returns just after the accept edge.
  task automatic start_word(input logic [31:0] value);
    start_in       = 1'b1;
    binary_data_in = value;
    tick();
    start_in       = 1'b0;
    binary_data_in = $urandom;
  endtask

  // Called in the cycle after accept; first valid expected BW+1 cycles after the accept cycle.
  task automatic wait_valid(input string name);
    int cnt;
    cnt = 1;
    chk({name, "_busy"}, busy_out, 1);
    while (!ascii_valid_out && cnt < 100) begin
      tick();
      cnt++;
    end
    chk({name, "_latency"}, cnt, BW + 1);
  endtask

  task automatic recv_word(input logic [79:0] text, input int mode, input string name);
    int         k;
    int         guard;
    bit         tog;
    bit         r;
    bit         stalled;
    logic [7:0] held_c;
    logic       held_l;
    k = 0; guard = 0; tog = 1'b0; stalled = 1'b0; held_c = '0; held_l = 1'b0;
    while (k < DL && guard < 400) begin
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      ascii_ready_in = r;
      chk({name, "_valid"}, ascii_valid_out, 1);
      if (stalled) begin
        chk({name, "_stall_char"}, ascii_char_out, held_c);
        chk({name, "_stall_last"}, ascii_last_out, held_l);
      end
      if (r) begin
        chk({name, "_char"}, ascii_char_out, text[79-8*k -: 8]);
        chk({name, "_last"}, ascii_last_out, (k == DL - 1));
        k++;
        stalled = 1'b0;
      end else begin
        held_c  = ascii_char_out;
        held_l  = ascii_last_out;
        stalled = 1'b1;
      end
      tick();
      guard++;
    end
    ascii_ready_in = 1'b0;
    chk({name, "_count"}, k, DL);
    chk({name, "_busy_after"}, busy_out, 0);
    chk({name, "_valid_after"}, ascii_valid_out, 0);
  endtask

  initial begin
    int seen;
    logic [31:0] v;

    vecs[0] = '{32'd12345678,  "0012345678", 0};
    vecs[1] = '{32'hFFFFFFFF,  "4294967295", 0};
    vecs[2] = '{32'd0,         "0000000000", 1};
    vecs[3] = '{32'd1,         "0000000001", 2};
    vecs[4] = '{32'd1000000000,"1000000000", 0};
    vecs[5] = '{32'd999999999, "0999999999", 2};

    rst_n          = 1'b0;
    start_in       = 1'b0;
    ascii_ready_in = 1'b0;
    binary_data_in = '0;
    tick();
    tick();
    chk("rst_busy",  busy_out, 0);
    chk("rst_valid", ascii_valid_out, 0);
    chk("rst_last",  ascii_last_out, 0);
    chk("rst_char",  ascii_char_out, 0);
    rst_n = 1'b1;

    // First start lands in the first cycle after reset release.
    for (int i = 0; i < 6; i++) begin
      start_word(vecs[i].value);
      wait_valid($sformatf("vec%0d", i));
      recv_word(vecs[i].text, vecs[i].mode, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      v = (i % 4 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
      start_word(v);
      wait_valid($sformatf("rnd%0d", i));
      recv_word(to_ascii(v), 2, $sformatf("rnd%0d", i));
    end

    // Start pulse with 99 during SEND of 7 must be ignored.
    start_word(32'd7);
    wait_valid("ign");
    ascii_ready_in = 1'b0;
    start_in       = 1'b1;
    binary_data_in = 32'd99;
    tick();
    start_in = 1'b0;
    chk("ign_stall_char", ascii_char_out, 8'h30);
    recv_word(to_ascii(32'd7), 0, "ign");
    seen = 0;
    repeat (40) begin
      if (ascii_valid_out || busy_out) seen++;
      tick();
    end
    chk("ign_no_99", seen, 0);

    // Reset while sending digit index 4 abandons the word.
    start_word(32'd4000000000);
    wait_valid("rstmid");
    ascii_ready_in = 1'b1;
    repeat (5) tick();
    ascii_ready_in = 1'b0;
    chk("rstmid_pre_char", ascii_char_out, 8'h30);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_busy",  busy_out, 0);
    chk("rstmid_valid", ascii_valid_out, 0);
    chk("rstmid_last",  ascii_last_out, 0);
    chk("rstmid_char",  ascii_char_out, 0);
    start_word(32'd5);
    wait_valid("rst5");
    recv_word(to_ascii(32'd5), 0, "rst5");

    // Back-to-back with start held high.
    start_in       = 1'b1;
    binary_data_in = 32'd1;
    tick();
    binary_data_in = 32'd2;
    wait_valid("b2b1");
    recv_word(to_ascii(32'd1), 0, "b2b1");
    tick();
    start_in = 1'b0;
    wait_valid("b2b2");
    recv_word(to_ascii(32'd2), 0, "b2b2");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/binary_to_ascii_converter.md
BINARY_TO_ASCII_CONVERTER -- requirements
Module: binary_to_ascii_converter

Interface
REQ-001 Parameter BIN_WIDTH, default 32: width of the binary input word.
REQ-002 Parameter DIGITS_LENGTH, default 10: number of decimal ASCII characters emitted per word; SHALL satisfy 10^DIGITS_LENGTH > 2^BIN_WIDTH - 1.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 binary_data_in  input  BIN_WIDTH  unsigned value to convert, sampled on accept.
REQ-007 start_in  input  1  request; accepted when high in a cycle where busy_out is low.
REQ-008 busy_out  output  1  high whenever state is not IDLE.
REQ-009 ascii_char_out  output  8  current ASCII digit character.
REQ-010 ascii_valid_out  output  1  ascii_char_out holds a valid character.
REQ-011 ascii_ready_in  input  1  downstream accepts the character this cycle.
REQ-012 ascii_last_out  output  1  high with the final (least significant) character of a word.

Function
REQ-013 FSM states SHALL be IDLE, CONVERT, SEND.
REQ-014 IDLE: start_in high -> capture binary_data_in, clear BCD register, load bit counter = BIN_WIDTH, go CONVERT; otherwise stay.
REQ-015 CONVERT: one double-dabble step per cycle (add 3 to every BCD nibble >= 5, then shift left one bit, MSB of binary first); after exactly BIN_WIDTH steps go SEND with digit index = DIGITS_LENGTH-1.
REQ-016 SEND: ascii_valid_out high; ascii_char_out = 8'h30 + BCD nibble[index], most significant digit first, leading zeros emitted (fixed DIGITS_LENGTH characters).
REQ-017 Handshake: transfer occurs when ascii_valid_out and ascii_ready_in are both high; ascii_char_out, ascii_last_out SHALL remain stable while valid is high and ready is low.
REQ-018 On transfer with index > 0: decrement index; on transfer with index = 0 (ascii_last_out high): go IDLE, ascii_valid_out low next cycle.
REQ-019 ascii_last_out SHALL be high only in SEND with index = 0.
REQ-020 Latency: start accepted in cycle N -> first ascii_valid_out in cycle N+BIN_WIDTH+1; with ready held high, last transfer in cycle N+BIN_WIDTH+DIGITS_LENGTH.
REQ-021 start_in while busy_out high SHALL be ignored; binary_data_in changes after accept SHALL not affect output.
REQ-022 start_in in the cycle the last transfer completes SHALL be ignored (accepted no earlier than next IDLE cycle).
REQ-023 Input 0 SHALL produce DIGITS_LENGTH characters 8'h30; input 2^BIN_WIDTH-1 SHALL convert without overflow.
REQ-024 ascii_ready_in held low indefinitely SHALL stall SEND without data loss or timeout.

Reset
REQ-025 rst_n low at a rising edge SHALL force IDLE, busy_out=0, ascii_valid_out=0, ascii_last_out=0, ascii_char_out=8'h00, BCD/shift registers and counters zero.
REQ-026 Reset mid-CONVERT or mid-SEND SHALL abandon the word; no further characters of it appear after reset release.
REQ-027 start_in in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-028 Shared package ascii_conv_pkg SHALL hold the state_t enum (IDLE, CONVERT, SEND) and constant ASCII_ZERO = 8'h30, shared with the receive-side converter.
REQ-029 Sub-module bin_to_bcd_seq SHALL implement the iterative double-dabble (start, done, bin_in, bcd_out); the top holds FSM, digit index and handshake.

Verification
REQ-030 BIN_WIDTH=32, DIGITS_LENGTH=10: start with 12345678, ready high -> "0012345678" (0x30,0x30,0x31..0x38), last on 0x38, first valid 33 cycles after accept.
REQ-031 Input 0xFFFFFFFF -> "4294967295", busy_out low the cycle after last transfer.
REQ-032 Input 0, ready toggling 1/0 each cycle -> ten 0x30 characters, char stable during every stall, last on tenth.
REQ-033 Second start_in pulse with value 99 during SEND of 7 -> only "0000000007" emitted, 99 never appears.
REQ-034 rst_n low for one cycle during SEND at digit index 4 -> all outputs zero next cycle; new start with 5 yields "0000000005" cleanly.
REQ-035 Back-to-back: start held high continuously with 1 then 2 -> "0000000001" then "0000000002", second accepted one IDLE cycle after first last transfer.
